rom_dl_router: RTL
==================

// Module: rom_dl_router
// PURPOSE
//  Sits between hps_io ioctl download stream and ROM stores: sdram ports 1/2, sound-ROM dpram, colour/height PROMs.
//  Buffers byte writes (index 0) in a FIFO, decodes region, issues toggle req/ack transfers to sdram.
//  Generates rom_loaded and stretched core reset.
// PARAMETERS
//  FIFO_DEPTH    8       entries of {addr[23:0],data[7:0]}; power of 2, >=4
//  RESET_CYCLES  16'hFFFF core_reset hold after release condition
//  SP_BASE       24'h30000 first byte routed to sdram port 2 (rebased to 0)
// PORTS
//  clk_sys        in   1   system clock
//  reset_n        in   1   async active-low reset
//  ioctl_download in   1   download active
//  ioctl_index    in   8   only index 0 accepted
//  ioctl_wr       in   1   one-cycle byte strobe
//  ioctl_addr     in   25  byte address
//  ioctl_dout     in   8   byte data
//  ioctl_wait     out  1   backpressure to hps_io
//  status_reset   in   1   OSD/button reset request, level
//  port1_req      out  1   toggle request, sdram port 1
//  port1_ack      in   1   toggle ack, port 1
//  port1_a        out  23  word address (byte addr[23:1])
//  port1_ds       out  2   {a[0],~a[0]}
//  port1_d        out  16  {data,data}
//  port2_req/_ack/_a/_ds/_d  as port1, address = addr-SP_BASE
//  snd_we/snd_addr/snd_data   out 1/16/8  sound dpram write
//  prom_we/prom_addr/prom_data out 1/12/8 PROM write (addr-0xA0000)
//  dl_busy        out  1   FIFO non-empty or FSM not IDLE
//  dl_overflow    out  1   sticky: write arrived while FIFO full
//  rom_loaded     out  1   sticky after first complete download
//  core_reset     out  1   active-high reset to target_top
// BEHAVIOUR
//  Reset values: req toggles 0, all we 0, addr/data 0, wait/busy/ovf/rom_loaded 0, core_reset 1.
//  Push: ioctl_download & ioctl_index==0 & ioctl_wr; other indices ignored.
//  Full push: dropped, dl_overflow<=1 (cleared only by reset_n).
//  ioctl_wait = count >= FIFO_DEPTH-2 (registered, 1-cycle slack).
//  Push+pop same cycle: count unchanged; pointers wrap mod FIFO_DEPTH.
//  Region decode on pop (a=addr):
//   a<0xA0000: sdram port1; also port2 if SP_BASE<=a<0x90000
//   0x20000<=a<0x30000: also snd_we pulse, snd_addr=a[15:0]
//   0xA0000<=a<0xA0920: prom_we only; a>=0xA0920 discarded
//  FSM IDLE->ISSUE->WAIT_ACK->IDLE:
//   IDLE: FIFO non-empty -> pop head to holding reg, ->ISSUE.
//   ISSUE: toggle req of each selected port in same cycle;
//     1-cycle snd_we/prom_we pulse; PROM/discard entries -> IDLE.
//   WAIT_ACK: -> IDLE when every toggled port has ack==req; no timeout.
//  Throughput: 1 entry / 3 clk + ack latency; a/ds/d stable from ISSUE to ack.
//  rom_loaded<=1 when download deasserted, FIFO empty, FSM IDLE.
//  Reload (download rises again): rom_loaded stays 1; core_reset forced 1.
//  core_reset: counter loads RESET_CYCLES while status_reset|ioctl_download|~rom_loaded|dl_busy;
//   else decrements to 0; core_reset = counter!=0 (registered).
//  reset_n low mid-transfer: FIFO flushed, FSM IDLE; in-flight sdram op not retracted.
// CONFIGURATION
//  ROM_CHECKSUM_EN defined: port rom_sum out 16 = mod-2^16 sum of all bytes popped
//   (discarded entries included); cleared on reset_n and on download rising edge.
//  Not defined: port and adder absent; all other behaviour identical.
// TESTING
//  Write 0x00000=0x12, 0x00001=0x34 -> two port1 req toggles; a=0, ds=01 then 10, d=1212/3434.
//  Write 0x30005=0xAB -> port1 a=0x18002 and port2 a=0x000002 toggled together; ds=10; IDLE only after both acks.
//  Write 0x2F00F=0x55 -> snd_we 1 cycle, snd_addr=0xF00F, data 0x55; port1 also toggled.
//  Hold ack 200 clk, stream 12 writes -> ioctl_wait at count 6, no overflow; ignore wait -> dl_overflow=1.
//  Write 0xA0900=0x07 -> prom_we, prom_addr=0x900, no req toggle; 0xA0920 -> nothing.
//  Download end -> rom_loaded 1, core_reset falls after 65535 clk; status_reset pulse reloads counter.

Source files
------------

// File: rtl/rom_dl_router.sv
// Download router: buffers ioctl bytes, routes them to sdram ports / sound dpram / PROMs, stretches core reset.
// Optional ROM_CHECKSUM_EN adds a rom_sum output (16-bit sum of every popped byte).
module rom_dl_router #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] RESET_CYCLES = 16'hFFFF,
    parameter logic [23:0] SP_BASE      = 24'h30000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        status_reset,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        snd_we,
    output logic [15:0] snd_addr,
    output logic [7:0]  snd_data,
    output logic        prom_we,
    output logic [11:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        dl_busy,
    output logic        dl_overflow,
    output logic        rom_loaded,
`ifdef ROM_CHECKSUM_EN
    output logic [15:0] rom_sum,
`endif
    output logic        core_reset
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          push_req, full, push, pop;
    logic [23:0]   entry_addr;
    logic [23:0]   hold_addr, sp_addr;
    logic [7:0]    hold_data;
    logic          in_sd, in_sp, in_snd, in_prom;
    logic          dl_seen;
    logic [15:0]   rst_cnt;

    // Addresses beyond 24 bits fall outside the ROM map and are forced into the discard range
    assign entry_addr = ioctl_addr[24] ? 24'hFFFFFF : ioctl_addr[23:0];
    assign push_req   = ioctl_download && (ioctl_index == 8'd0) && ioctl_wr;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign push       = push_req && !full;
    assign pop        = (state == S_IDLE) && (count != '0);

    assign in_sd   = hold_addr < 24'hA0000;
    assign in_sp   = (hold_addr >= SP_BASE) && (hold_addr < 24'h90000);
    assign in_snd  = (hold_addr >= 24'h20000) && (hold_addr < 24'h30000);
    assign in_prom = (hold_addr >= 24'hA0000) && (hold_addr < 24'hA0920);
    assign sp_addr = hold_addr - SP_BASE;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CW'(1);
        else if (!push && pop)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (count != '0) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = in_sd ? S_WAIT : S_IDLE;
            S_WAIT:  if ((port1_ack == port1_req) && (!in_sp || (port2_ack == port2_req)))
                         state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: a flush only clears the pointers
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {entry_addr, ioctl_dout};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            hold_addr   <= '0;
            hold_data   <= '0;
            ioctl_wait  <= 1'b0;
            dl_busy     <= 1'b0;
            dl_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr                 <= rd_ptr + PW'(1);
                {hold_addr, hold_data} <= mem[rd_ptr];
            end
            count       <= count_nxt;
            ioctl_wait  <= count_nxt >= CW'(FIFO_DEPTH - 2);
            dl_busy     <= (count_nxt != '0) || (state_nxt != S_IDLE);
            dl_overflow <= dl_overflow || (push_req && full);
        end
    end

    // Sink side: address/data held from ISSUE until the next entry for that port
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            port1_req <= 1'b0;  port1_a <= '0;  port1_ds <= '0;  port1_d <= '0;
            port2_req <= 1'b0;  port2_a <= '0;  port2_ds <= '0;  port2_d <= '0;
            snd_we    <= 1'b0;  snd_addr <= '0; snd_data <= '0;
            prom_we   <= 1'b0;  prom_addr <= '0; prom_data <= '0;
        end else begin
            snd_we  <= 1'b0;
            prom_we <= 1'b0;
            if (state == S_ISSUE) begin
                if (in_sd) begin
                    port1_req <= ~port1_req;
                    port1_a   <= hold_addr[23:1];
                    port1_ds  <= {hold_addr[0], ~hold_addr[0]};
                    port1_d   <= {hold_data, hold_data};
                end
                if (in_sp) begin
                    port2_req <= ~port2_req;
                    port2_a   <= sp_addr[23:1];
                    port2_ds  <= {sp_addr[0], ~sp_addr[0]};
                    port2_d   <= {hold_data, hold_data};
                end
                if (in_snd) begin
                    snd_we   <= 1'b1;
                    snd_addr <= hold_addr[15:0];
                    snd_data <= hold_data;
                end
                if (in_prom) begin
                    prom_we   <= 1'b1;
                    prom_addr <= hold_addr[11:0];
                    prom_data <= hold_data;
                end
            end
        end
    end

    // rom_loaded needs a download to have actually happened before it can latch
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_seen    <= 1'b0;
            rom_loaded <= 1'b0;
            rst_cnt    <= RESET_CYCLES;
            core_reset <= 1'b1;
        end else begin
            dl_seen    <= dl_seen || ioctl_download;
            rom_loaded <= rom_loaded ||
                          (dl_seen && !ioctl_download && (count == '0) && (state == S_IDLE));
            if (status_reset || ioctl_download || !rom_loaded || dl_busy)
                rst_cnt <= RESET_CYCLES;
            else if (rst_cnt != 16'd0)
                rst_cnt <= rst_cnt - 16'd1;
            core_reset <= (rst_cnt != 16'd0);
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic dl_prev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_prev <= 1'b0;
            rom_sum <= '0;
        end else begin
            dl_prev <= ioctl_download;
            if (ioctl_download && !dl_prev)
                rom_sum <= '0;
            else if (pop)
                rom_sum <= rom_sum + 16'(mem[rd_ptr][7:0]);
        end
    end
`endif

endmodule
